// File: rtl/telemetry_frame_tx.sv
// Telemetry framer: snapshots N_FIELDS payload bytes on a report tick and streams
// one frame (header, fields, padding, checksum, CRLF) into a UART via ready/send.
module telemetry_frame_tx #(
    parameter int         N_FIELDS     = 3,
    parameter int         USE_HEADER   = 1,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5,
    parameter int         PAD_BYTES    = 0,
    parameter int         USE_CHECKSUM = 1,
    parameter int         USE_CRLF     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic [8*N_FIELDS-1:0] fields_in,
    input  logic                  tx_ready,
    output logic                  tx_send,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            overrun_cnt
);

    localparam int HDR_N      = (USE_HEADER != 0) ? 1 : 0;
    localparam int CSUM_N     = (USE_CHECKSUM != 0) ? 1 : 0;
    localparam int CRLF_N     = (USE_CRLF != 0) ? 1 : 0;
    localparam int FIELD_BASE = HDR_N;
    localparam int PAD_BASE   = FIELD_BASE + N_FIELDS;
    localparam int CSUM_POS   = PAD_BASE + PAD_BYTES;
    localparam int CR_POS     = CSUM_POS + CSUM_N;
    localparam int FRAME_LEN  = CR_POS + 2 * CRLF_N;
    localparam int IDX_W      = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEND, HOLD, WAIT} state_t;

    state_t                state;
    state_t                state_next;
    logic [8*N_FIELDS-1:0] snapshot;
    logic [IDX_W-1:0]      byte_idx;
    logic [7:0]            csum;
    logic [7:0]            cur_byte;
    logic                  is_field;
    logic                  last_byte;
    logic                  accept;
    logic                  strobe;
    logic                  finish;
    logic                  advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (trigger)   state_next = SEND;
            SEND: if (tx_ready)  state_next = HOLD;
            HOLD: if (!tx_ready) state_next = WAIT;
            WAIT: if (tx_ready)  state_next = last_byte ? IDLE : SEND;
            default:             state_next = IDLE;
        endcase
    end

    always_comb begin
        last_byte = (byte_idx == LAST_IDX);
        accept    = (state == IDLE) && trigger;
        strobe    = (state == SEND) && tx_ready;
        finish    = (state == WAIT) && tx_ready && last_byte;
        advance   = (state == WAIT) && tx_ready && !last_byte;
    end

    // Padding positions fall through to the 0x00 default.
    always_comb begin
        cur_byte = 8'h00;
        is_field = 1'b0;
        if (HDR_N != 0 && byte_idx == IDX_W'(0)) begin
            cur_byte = HEADER_BYTE;
        end
        for (int k = 0; k < N_FIELDS; k++) begin
            if (byte_idx == IDX_W'(FIELD_BASE + k)) begin
                cur_byte = snapshot[8*k +: 8];
                is_field = 1'b1;
            end
        end
        if (CSUM_N != 0 && byte_idx == IDX_W'(CSUM_POS)) begin
            cur_byte = csum;
        end
        if (CRLF_N != 0 && byte_idx == IDX_W'(CR_POS)) begin
            cur_byte = 8'h0D;
        end
        if (CRLF_N != 0 && byte_idx == IDX_W'(CR_POS + 1)) begin
            cur_byte = 8'h0A;
        end
    end

    // Checksum accumulates at each field strobe, so it is complete by its own slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_send     <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun_cnt <= 8'h00;
            snapshot    <= '0;
            byte_idx    <= '0;
            csum        <= 8'h00;
        end else begin
            tx_send    <= strobe;
            frame_done <= finish;
            if (accept) begin
                snapshot <= fields_in;
                byte_idx <= '0;
                csum     <= 8'h00;
                busy     <= 1'b1;
            end
            if (strobe) begin
                tx_data <= cur_byte;
                if (is_field) begin
                    csum <= csum + cur_byte;
                end
            end
            if (advance) begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
            if (finish) begin
                busy <= 1'b0;
            end
            if (trigger && busy && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Bench for telemetry_frame_tx: two configurations, a UART ready model per DUT,
// and a frame-level reference model that builds expected byte sequences.
module tb_telemetry_frame_tx;

    logic        clk;
    logic        reset;
    logic        trigger_a, trigger_b;
    logic [23:0] fields_a;
    logic [15:0] fields_b;
    logic        tx_ready_a, tx_ready_b;
    logic        tx_send_a, tx_send_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        busy_a, busy_b;
    logic        frame_done_a, frame_done_b;
    logic [7:0]  overrun_a, overrun_b;

    int          total, bad;
    logic [7:0]  cap_a[$], exp_a[$], cap_b[$], exp_b[$];
    int          cnt_a, cnt_b, done_a, done_b, viol_a, viol_b;
    bit          block_a, block_b;

    telemetry_frame_tx #(.N_FIELDS(3)) dut_a (
        .clk(clk), .reset(reset), .trigger(trigger_a), .fields_in(fields_a),
        .tx_ready(tx_ready_a), .tx_send(tx_send_a), .tx_data(tx_data_a),
        .busy(busy_a), .frame_done(frame_done_a), .overrun_cnt(overrun_a)
    );

    telemetry_frame_tx #(.N_FIELDS(2), .USE_HEADER(0), .PAD_BYTES(3), .USE_CHECKSUM(0)) dut_b (
        .clk(clk), .reset(reset), .trigger(trigger_b), .fields_in(fields_b),
        .tx_ready(tx_ready_b), .tx_send(tx_send_b), .tx_data(tx_data_b),
        .busy(busy_b), .frame_done(frame_done_b), .overrun_cnt(overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART models: capture each strobe, go unready for a random 1..20 cycles.
    always @(negedge clk) begin
        if (tx_send_a) begin
            if (!tx_ready_a) viol_a++;
            cap_a.push_back(tx_data_a);
            cnt_a = $urandom_range(20, 1);
            tx_ready_a = 1'b0;
        end else if (cnt_a > 0) begin
            cnt_a--;
        end
        if (!tx_send_a && cnt_a == 0) tx_ready_a = !block_a;
        if (frame_done_a) done_a++;
    end

    always @(negedge clk) begin
        if (tx_send_b) begin
            if (!tx_ready_b) viol_b++;
            cap_b.push_back(tx_data_b);
            cnt_b = $urandom_range(20, 1);
            tx_ready_b = 1'b0;
        end else if (cnt_b > 0) begin
            cnt_b--;
        end
        if (!tx_send_b && cnt_b == 0) tx_ready_b = !block_b;
        if (frame_done_b) done_b++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference frame: header, fields, zero padding, mod-256 field sum, CR LF.
    task automatic expectFrame(input int which, input logic [7:0] f[16]);
        int n, pad, sum;
        bit hdr, cs;
        logic [7:0] q[$];
        n   = (which == 0) ? 3 : 2;
        hdr = (which == 0);
        pad = (which == 0) ? 0 : 3;
        cs  = (which == 0);
        sum = 0;
        if (hdr) q.push_back(8'hA5);
        for (int k = 0; k < n; k++) begin
            q.push_back(f[k]);
            sum += int'(f[k]);
        end
        for (int k = 0; k < pad; k++) q.push_back(8'h00);
        if (cs) q.push_back(8'(sum % 256));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        foreach (q[i]) begin
            if (which == 0) exp_a.push_back(q[i]);
            else            exp_b.push_back(q[i]);
        end
    endtask

    task automatic checkFrame(input string tag, input int which);
        logic [7:0] c[$];
        logic [7:0] e[$];
        int n;
        if (which == 0) begin
            c = cap_a; e = exp_a; cap_a.delete(); exp_a.delete();
        end else begin
            c = cap_b; e = exp_b; cap_b.delete(); exp_b.delete();
        end
        checkOutput({tag, "_len"}, 32'(c.size()), 32'(e.size()));
        n = (c.size() < e.size()) ? c.size() : e.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(c[i]), 32'(e[i]));
        end
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] f[16]);
        if (which == 0) begin
            fields_a  = {f[2], f[1], f[0]};
            trigger_a = 1'b1;
        end else begin
            fields_b  = {f[1], f[0]};
            trigger_b = 1'b1;
        end
        @(negedge clk);
        trigger_a = 1'b0;
        trigger_b = 1'b0;
    endtask

    // Returns at the negedge where frame_done is high.
    task automatic waitDone(input string tag, input int which);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if ((which == 0) ? frame_done_a : frame_done_b) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_busy_end"}, 32'((which == 0) ? busy_a : busy_b), 32'd0);
    endtask

    task automatic pulseTriggers(input int n);
        for (int i = 0; i < n; i++) begin
            trigger_a = 1'b1;
            @(negedge clk);
            trigger_a = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic randFields(output logic [7:0] f[16]);
        for (int k = 0; k < 16; k++) f[k] = 8'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] f[16];
        int d0, n0;
        total = 0; bad = 0;
        cnt_a = 0; cnt_b = 0; done_a = 0; done_b = 0; viol_a = 0; viol_b = 0;
        block_a = 0; block_b = 0;
        tx_ready_a = 1'b1; tx_ready_b = 1'b1;
        trigger_a = 0; trigger_b = 0; fields_a = '0; fields_b = '0;
        for (int k = 0; k < 16; k++) f[k] = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_send", 32'(tx_send_a), 32'd0);
        checkOutput("rst_data", 32'(tx_data_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_done", 32'(frame_done_a), 32'd0);
        checkOutput("rst_ovr", 32'(overrun_a), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame and first-strobe latency
        f[0] = 8'h12; f[1] = 8'h34; f[2] = 8'h56;
        expectFrame(0, f);
        d0 = done_a;
        applyStimulus(0, f);
        checkOutput("lat_e0_send", 32'(tx_send_a), 32'd0);
        checkOutput("lat_e0_busy", 32'(busy_a), 32'd1);
        @(negedge clk);
        checkOutput("lat_e1_send", 32'(tx_send_a), 32'd1);
        checkOutput("lat_e1_data", 32'(tx_data_a), 32'hA5);
        waitDone("t1", 0);
        repeat (5) @(negedge clk);
        checkFrame("t1", 0);
        checkOutput("t1_done_cnt", 32'(done_a - d0), 32'd1);

        // Checksum wrap and snapshot isolation
        f[0] = 8'hFF; f[1] = 8'hFF; f[2] = 8'h03;
        expectFrame(0, f);
        applyStimulus(0, f);
        repeat (10) @(negedge clk);
        fields_a = 24'($urandom);
        waitDone("t2", 0);
        repeat (3) @(negedge clk);
        checkFrame("t2", 0);

        for (int r = 0; r < 4; r++) begin
            randFields(f);
            expectFrame(0, f);
            applyStimulus(0, f);
            repeat ($urandom_range(12, 1)) @(negedge clk);
            fields_a = 24'($urandom);
            waitDone("rnd", 0);
            repeat (3) @(negedge clk);
            checkFrame($sformatf("rnd%0d", r), 0);
        end

        // Overruns during a frame, then saturation while stalled
        randFields(f);
        expectFrame(0, f);
        d0 = done_a;
        applyStimulus(0, f);
        pulseTriggers(3);
        waitDone("t3a", 0);
        repeat (3) @(negedge clk);
        checkOutput("t3_ovr3", 32'(overrun_a), 32'd3);
        checkFrame("t3a", 0);
        randFields(f);
        expectFrame(0, f);
        block_a = 1'b1;
        applyStimulus(0, f);
        pulseTriggers(251);
        checkOutput("t3_ovr254", 32'(overrun_a), 32'd254);
        pulseTriggers(1);
        checkOutput("t3_ovr255", 32'(overrun_a), 32'd255);
        pulseTriggers(48);
        checkOutput("t3_sat", 32'(overrun_a), 32'd255);
        block_a = 1'b0;
        waitDone("t3b", 0);
        repeat (30) @(negedge clk);
        checkFrame("t3b", 0);
        checkOutput("t3_frames", 32'(done_a - d0), 32'd2);
        checkOutput("t3_no_extra", 32'(cap_a.size()), 32'd0);

        // Stalled UART, then a trigger on the frame_done cycle
        block_a = 1'b1;
        randFields(f);
        expectFrame(0, f);
        applyStimulus(0, f);
        repeat (50) @(negedge clk);
        checkOutput("t5_no_send", 32'(cap_a.size()), 32'd0);
        checkOutput("t5_busy", 32'(busy_a), 32'd1);
        block_a = 1'b0;
        waitDone("t5a", 0);
        randFields(f);
        expectFrame(0, f);
        applyStimulus(0, f);
        waitDone("t5b", 0);
        repeat (3) @(negedge clk);
        checkFrame("t5", 0);
        checkOutput("t5_ovr_same", 32'(overrun_a), 32'd255);

        // Reset mid-frame after the third byte
        randFields(f);
        applyStimulus(0, f);
        for (int i = 0; i < 2000 && cap_a.size() < 3; i++) @(negedge clk);
        checkOutput("t6_reached3", 32'(cap_a.size()), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_send", 32'(tx_send_a), 32'd0);
        checkOutput("t6_busy", 32'(busy_a), 32'd0);
        checkOutput("t6_ovr", 32'(overrun_a), 32'd0);
        reset = 1'b0;
        n0 = cap_a.size();
        repeat (40) @(negedge clk);
        checkOutput("t6_no_resume", 32'(cap_a.size()), 32'(n0));
        cap_a.delete();
        reset = 1'b1;
        trigger_a = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        trigger_a = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_trig_busy", 32'(busy_a), 32'd0);
        repeat (30) @(negedge clk);
        checkOutput("t6_rst_trig_send", 32'(cap_a.size()), 32'd0);
        randFields(f);
        expectFrame(0, f);
        applyStimulus(0, f);
        waitDone("t6", 0);
        repeat (3) @(negedge clk);
        checkFrame("t6", 0);

        // No header, padding, no checksum
        f[0] = 8'h11; f[1] = 8'h22;
        expectFrame(1, f);
        applyStimulus(1, f);
        waitDone("t4", 1);
        repeat (3) @(negedge clk);
        checkFrame("t4", 1);
        for (int r = 0; r < 2; r++) begin
            randFields(f);
            expectFrame(1, f);
            applyStimulus(1, f);
            fields_b = 16'($urandom);
            waitDone("t4r", 1);
            repeat (3) @(negedge clk);
            checkFrame($sformatf("t4r%0d", r), 1);
        end
        checkOutput("t4_ovr", 32'(overrun_b), 32'd0);

        checkOutput("proto_a", 32'(viol_a), 32'd0);
        checkOutput("proto_b", 32'(viol_b), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
